// File: rtl/dma_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dma_xfer_sequencer
//  Description : Multi-channel DMA timing/control sequencer. Services one
//                channel at a time, keeps per-channel base/current address
//                and word count, and drives Moore-decoded bus strobes.
//                Supports single/block/demand service, autoinitialize,
//                Ready wait states, external EOP abort and an upper-address
//                strobe that fires whenever the high address bits change.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_xfer_sequencer #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int LO_W   = 8,   // must be below ADDR_W
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic [NUM_CH-1:0]        CfgLoad,
  input  logic [NUM_CH*ADDR_W-1:0] BaseAddr,
  input  logic [NUM_CH*CNT_W-1:0]  BaseCount,
  input  logic [2*NUM_CH-1:0]      ModeXfer,
  input  logic [2*NUM_CH-1:0]      ModeSvc,
  input  logic [NUM_CH-1:0]        ModeDec,
  input  logic [NUM_CH-1:0]        ModeAuto,
  input  logic                     ReqValid,
  input  logic [CH_W-1:0]          ReqID,
  input  logic [NUM_CH-1:0]        Dreq,
  input  logic                     Hlda,
  input  logic                     Ready,
  input  logic                     nEOPIn,
  input  logic                     TcClear,
  output logic                     Hrq,
  output logic                     Aen,
  output logic                     Adstb,
  output logic [NUM_CH-1:0]        Dack,
  output logic [ADDR_W-1:0]        AddrOut,
  output logic                     BusDrive,
  output logic                     nIOR,
  output logic                     nIOW,
  output logic                     nMEMR,
  output logic                     nMEMW,
  output logic                     nEOPOut,
  output logic [NUM_CH-1:0]        TcStatus
);

  localparam logic [1:0]        C_XFER_WRITE = 2'b01;
  localparam logic [1:0]        C_XFER_READ  = 2'b10;
  localparam logic [1:0]        C_SVC_DEMAND = 2'b00;
  localparam logic [1:0]        C_SVC_BLOCK  = 2'b10;
  localparam logic [ADDR_W-1:0] C_ADDR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_S1 = 3'd2,
    ST_S2 = 3'd3,
    ST_S3 = 3'd4,
    ST_SW = 3'd5,
    ST_S4 = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic              abort_q, abort_d;
  // Mode of the channel in service, captured at grant so that the output
  // decode depends on registers only.
  logic [1:0]        xfer_q, svc_q;
  logic              dec_q, auto_q;

  logic [ADDR_W-1:0] base_addr_q [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_q  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] tc_q;

  logic [1:0]        w_xfer_sel [NUM_CH];
  logic [1:0]        w_svc_sel  [NUM_CH];
  logic [ADDR_W-1:0] w_base_addr_in [NUM_CH];
  logic [CNT_W-1:0]  w_base_cnt_in  [NUM_CH];

  logic [ADDR_W-1:0] w_act_addr, w_new_addr;
  logic [CNT_W-1:0]  w_act_cnt;
  logic              w_tc, w_end, w_continue, w_hi_change, w_commit;
  logic              w_bus, w_rd_phase, w_wr_phase;

  // Unpack the flat per-channel buses into indexable arrays.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_xfer_sel[g]     = ModeXfer[2*g +: 2];
    assign w_svc_sel[g]      = ModeSvc[2*g +: 2];
    assign w_base_addr_in[g] = BaseAddr[g*ADDR_W +: ADDR_W];
    assign w_base_cnt_in[g]  = BaseCount[g*CNT_W +: CNT_W];
  end

  assign w_act_addr  = cur_addr_q[act_q];
  assign w_act_cnt   = cur_cnt_q[act_q];
  assign w_new_addr  = dec_q ? (w_act_addr - C_ADDR_ONE) : (w_act_addr + C_ADDR_ONE);
  assign w_hi_change = (w_new_addr[ADDR_W-1:LO_W] != w_act_addr[ADDR_W-1:LO_W]);
  assign w_tc        = (w_act_cnt == '0);
  assign w_end       = w_tc || abort_q || !nEOPIn;
  assign w_continue  = (svc_q == C_SVC_BLOCK) ||
                       ((svc_q == C_SVC_DEMAND) && Dreq[act_q]);
  assign w_commit    = (state_q == ST_S4) && Hlda;

  // Next-state decision; losing Hlda anywhere on the bus abandons the cycle.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    abort_d = abort_q;
    case (state_q)
      ST_SI: begin
        if (ReqValid) begin
          act_d   = ReqID;
          state_d = ST_S0;
        end
      end
      ST_S0: if (Hlda) state_d = ST_S1;
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3, ST_SW: state_d = Ready ? ST_S4 : ST_SW;
      ST_S4: begin
        if (w_end || !w_continue) state_d = ST_SI;
        else                      state_d = w_hi_change ? ST_S1 : ST_S2;
      end
      default: state_d = ST_SI;
    endcase
    if ((state_q inside {ST_S1, ST_S2, ST_S3, ST_SW}) && !nEOPIn) abort_d = 1'b1;
    if (w_bus && !Hlda) state_d = ST_SI;
    if (state_d == ST_SI) abort_d = 1'b0;
  end

  // State, mode capture and per-channel address/count/TC registers.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q <= ST_SI;
      act_q   <= '0;
      abort_q <= 1'b0;
      xfer_q  <= '0;
      svc_q   <= '0;
      dec_q   <= 1'b0;
      auto_q  <= 1'b0;
      tc_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      abort_q <= abort_d;
      if ((state_q == ST_SI) && ReqValid) begin
        xfer_q <= w_xfer_sel[ReqID];
        svc_q  <= w_svc_sel[ReqID];
        dec_q  <= ModeDec[ReqID];
        auto_q <= ModeAuto[ReqID];
      end
      if (TcClear) tc_q <= '0;
      // Reprogramming the channel in service would corrupt it, so skip it.
      for (int i = 0; i < NUM_CH; i++) begin
        if (CfgLoad[i] && ((state_q == ST_SI) || (CH_W'(i) != act_q))) begin
          base_addr_q[i] <= w_base_addr_in[i];
          cur_addr_q[i]  <= w_base_addr_in[i];
          base_cnt_q[i]  <= w_base_cnt_in[i];
          cur_cnt_q[i]   <= w_base_cnt_in[i];
          tc_q[i]        <= 1'b0;
        end
      end
      if (w_commit) begin
        if (w_end && auto_q) begin
          cur_addr_q[act_q] <= base_addr_q[act_q];
          cur_cnt_q[act_q]  <= base_cnt_q[act_q];
        end else begin
          cur_addr_q[act_q] <= w_new_addr;
          cur_cnt_q[act_q]  <= w_act_cnt - C_CNT_ONE;
        end
        // Placed after the clears so a same-cycle TC set wins.
        if (w_tc) tc_q[act_q] <= 1'b1;
      end
    end
  end

  assign w_bus      = state_q inside {ST_S1, ST_S2, ST_S3, ST_SW, ST_S4};
  assign w_rd_phase = state_q inside {ST_S2, ST_S3, ST_SW, ST_S4};
  assign w_wr_phase = (state_q == ST_S4);

  assign Hrq      = (state_q != ST_SI);
  assign Aen      = w_bus;
  assign BusDrive = w_bus;
  assign Adstb    = (state_q == ST_S1);
  assign Dack     = w_bus ? (NUM_CH'(1) << act_q) : '0;
  assign AddrOut  = w_act_addr;
  assign nIOR     = !(w_rd_phase && (xfer_q == C_XFER_WRITE));
  assign nMEMR    = !(w_rd_phase && (xfer_q == C_XFER_READ));
  assign nMEMW    = !(w_wr_phase && (xfer_q == C_XFER_WRITE));
  assign nIOW     = !(w_wr_phase && (xfer_q == C_XFER_READ));
  assign nEOPOut  = !(w_wr_phase && w_tc);
  assign TcStatus = tc_q;

endmodule
`default_nettype wire
